retospect_neuron_cell: RTL and testbench

RETOSPECT_NEURON_CELL -- requirements
Module: retospect_neuron_cell

---
 rtl/retospect_neuron_pkg.sv | 36 +++
 rtl/retospect_cfg_shreg.sv | 28 ++
 rtl/retospect_neuron_cell.sv | 152 +++++++++++++++
 tb/tb_retospect_neuron_cell.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/retospect_neuron_pkg.sv
// Shared definitions for the retospect neuron cell: default widths, the
// configuration chain length and the chain field layout.
// Optional feature macro: RETOSPECT_NEURON_REFRACTORY_EN (adds the
// refractory field and counter).
package retospect_neuron_pkg;

    localparam int DEF_NUM_DEND  = 4;
    localparam int DEF_W_WIDTH   = 4;
    localparam int DEF_POT_WIDTH = 6;
    localparam int DEF_SEL_WIDTH = 3;
    localparam int DEF_REF_WIDTH = 3;

`ifdef RETOSPECT_NEURON_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    // Total serial chain length; the refractory field only exists when enabled.
    function automatic int chain_len(input int nd, input int ww, input int pw,
                                     input int sw, input int rw);
        return nd * ww + pw + sw + (REF_EN ? rw : 0);
    endfunction

    // Chain layout at default widths. The first declared field sits at the
    // MSB end (next to bs_in); weights holds w[0] in its top W_WIDTH bits.
    typedef struct packed {
        logic [DEF_NUM_DEND*DEF_W_WIDTH-1:0] weights;
        logic [DEF_POT_WIDTH-1:0]            thr;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
        logic [DEF_REF_WIDTH-1:0]            refr;
`endif
        logic [DEF_SEL_WIDTH-1:0]            sel;
    } cfg_fields_t;

endpackage

// File: rtl/retospect_cfg_shreg.sv
// Serial-in / parallel-out configuration shift register. Bits enter at the
// MSB and leave from the LSB; async active-low clear empties the whole chain.
module retospect_cfg_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] par_o,
    output logic             ser_o
);

    logic [WIDTH-1:0] chain_q;

    // Shift one bit towards the LSB per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else if (shift_en_i) begin
            chain_q <= {ser_i, chain_q[WIDTH-1:1]};
        end
    end

    assign par_o = chain_q;
    assign ser_o = chain_q[0];

endmodule

// File: rtl/retospect_neuron_cell.sv
// Leaky integrate-and-fire neuron cell with a serial configuration chain.
// Optional feature macro: RETOSPECT_NEURON_REFRACTORY_EN (refractory period
// field in the chain plus a per-cell refractory counter).
module retospect_neuron_cell
    import retospect_neuron_pkg::*;
#(
    parameter int NUM_DEND  = DEF_NUM_DEND,
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int POT_WIDTH = DEF_POT_WIDTH,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH,
    parameter int REF_WIDTH = DEF_REF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reset_nn,
    input  logic                      config_en,
    input  logic                      bs_in,
    output logic                      bs_out,
    input  logic [(1<<SEL_WIDTH)-1:0] clockbus,
    input  logic [NUM_DEND-1:0]       dendrite,
    output logic                      axon
);

    localparam int CHAIN_LEN = chain_len(NUM_DEND, W_WIDTH, POT_WIDTH, SEL_WIDTH, REF_WIDTH);
    localparam int REF_BITS  = REF_EN ? REF_WIDTH : 0;
    localparam int THR_LO    = SEL_WIDTH + REF_BITS;
    localparam int W_LO      = THR_LO + POT_WIDTH;
    // Wide enough that decayed potential plus all weights never wraps.
    localparam int SUM_W     = POT_WIDTH + W_WIDTH + $clog2(NUM_DEND) + 1;
    localparam logic [POT_WIDTH-1:0] POT_ONE = POT_WIDTH'(1);

    // Clamp a signed intermediate into the unsigned potential range.
    function automatic logic [POT_WIDTH-1:0] sat_pot(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1]) begin
            return '0;
        end else if (|v[SUM_W-2:POT_WIDTH]) begin
            return '1;
        end else begin
            return v[POT_WIDTH-1:0];
        end
    endfunction

    logic [CHAIN_LEN-1:0]        cfg_vec;
    logic [SEL_WIDTH-1:0]        sel_f;
    logic [POT_WIDTH-1:0]        thr_f;
    logic signed [W_WIDTH-1:0]   w_arr [NUM_DEND];

    logic [POT_WIDTH-1:0]        pot_q, pot_d;
    logic                        axon_q, axon_d;

    logic [POT_WIDTH-1:0]        decayed_c;
    logic signed [SUM_W-1:0]     dec_ext_c;
    logic signed [SUM_W-1:0]     sum_c;
    logic signed [SUM_W-1:0]     nxt_c;
    logic [POT_WIDTH-1:0]        pot_sat_c;
    logic                        fire_c;

`ifdef RETOSPECT_NEURON_REFRACTORY_EN
    logic [REF_WIDTH-1:0]        ref_f;
    logic [REF_WIDTH-1:0]        refcnt_q, refcnt_d;
`endif

    // Reset outranks soft reset, which outranks configuration shifting.
    retospect_cfg_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (config_en & ~reset_nn),
        .ser_i      (bs_in),
        .par_o      (cfg_vec),
        .ser_o      (bs_out)
    );

    assign sel_f = cfg_vec[SEL_WIDTH-1:0];
    assign thr_f = cfg_vec[THR_LO +: POT_WIDTH];
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
    assign ref_f = cfg_vec[SEL_WIDTH +: REF_WIDTH];
`endif

    // w[0] is the field closest to bs_in, i.e. the most significant weight slot.
    for (genvar g = 0; g < NUM_DEND; g++) begin : g_w
        assign w_arr[g] = cfg_vec[W_LO + (NUM_DEND-1-g)*W_WIDTH +: W_WIDTH];
    end

    // Integrate: optional halving decay, then add every active dendrite weight.
    always_comb begin
        decayed_c = clockbus[sel_f] ? (pot_q >> 1) : pot_q;
        dec_ext_c = $signed({{(SUM_W-POT_WIDTH){1'b0}}, decayed_c});
        sum_c     = '0;
        for (int i = 0; i < NUM_DEND; i++) begin
            if (dendrite[i]) begin
                sum_c = sum_c + SUM_W'(w_arr[i]);
            end
        end
        nxt_c     = dec_ext_c + sum_c;
        pot_sat_c = sat_pot(nxt_c);
        fire_c    = (thr_f != '0) && (pot_sat_c >= thr_f);
    end

    // Next-state selection: soft reset, config hold, refractory, fire, integrate.
    always_comb begin
        pot_d  = pot_q;
        axon_d = 1'b0;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
        refcnt_d = refcnt_q;
`endif
        if (reset_nn) begin
            pot_d = POT_ONE;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
            refcnt_d = '0;
`endif
        end else if (config_en) begin
            pot_d = pot_q;
        end
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
        else if (refcnt_q != '0) begin
            pot_d    = '0;
            refcnt_d = refcnt_q - REF_WIDTH'(1);
        end
`endif
        else if (fire_c) begin
            axon_d = 1'b1;
            pot_d  = '0;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
            refcnt_d = ref_f;
`endif
        end else begin
            pot_d = pot_sat_c;
        end
    end

    // Dynamic state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pot_q  <= '0;
            axon_q <= 1'b0;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
            refcnt_q <= '0;
`endif
        end else begin
            pot_q  <= pot_d;
            axon_q <= axon_d;
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
            refcnt_q <= refcnt_d;
`endif
        end
    end

    assign axon = axon_q;

endmodule

// File: tb/tb_retospect_neuron_cell.sv
// Self-checking bench for retospect_neuron_cell at default parameters.
// Works with RETOSPECT_NEURON_REFRACTORY_EN defined or undefined.
module tb_retospect_neuron_cell;
    import retospect_neuron_pkg::*;

    localparam int L = chain_len(DEF_NUM_DEND, DEF_W_WIDTH, DEF_POT_WIDTH,
                                 DEF_SEL_WIDTH, DEF_REF_WIDTH);

    logic       clk = 1'b0;
    logic       rst_n, reset_nn, config_en, bs_in, bs_out, axon;
    logic [7:0] clockbus;
    logic [3:0] dendrite;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      nm;
        logic [3:0] dend;
        logic [7:0] cb;
        logic       ea;
        logic [5:0] ep;
    } vec_t;

    typedef struct {
        string      nm;
        logic       ea;
        logic [5:0] ep;
    } exp_t;

    vec_t       vtab[$];
    exp_t       sbq[$];
    logic [L-1:0] cur_chain;

    retospect_neuron_cell #(
        .NUM_DEND  (DEF_NUM_DEND),
        .W_WIDTH   (DEF_W_WIDTH),
        .POT_WIDTH (DEF_POT_WIDTH),
        .SEL_WIDTH (DEF_SEL_WIDTH),
        .REF_WIDTH (DEF_REF_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reset_nn  (reset_nn),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .clockbus  (clockbus),
        .dendrite  (dendrite),
        .axon      (axon)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void addv(input string nm, input logic [3:0] d, input logic [7:0] cb,
                                 input logic ea, input logic [5:0] ep);
        vec_t v;
        v.nm = nm; v.dend = d; v.cb = cb; v.ea = ea; v.ep = ep;
        vtab.push_back(v);
    endfunction

    function automatic logic [L-1:0] mk(input int w0, input int w1, input int w2, input int w3,
                                        input int thr, input int sel);
        cfg_fields_t c;
        c.weights = {DEF_W_WIDTH'(w0), DEF_W_WIDTH'(w1), DEF_W_WIDTH'(w2), DEF_W_WIDTH'(w3)};
        c.thr     = DEF_POT_WIDTH'(thr);
`ifdef RETOSPECT_NEURON_REFRACTORY_EN
        c.refr    = '0;
`endif
        c.sel     = DEF_SEL_WIDTH'(sel);
        return c;
    endfunction

    // Shift nbits of 'bits' (bit 0 first); bs_out must replay the previous chain.
    task automatic shift_cfg(input logic [L-1:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            check("bs_out", {31'b0, bs_out}, {31'b0, cur_chain[i]});
            config_en = 1'b1;
            bs_in     = bits[i];
            @(negedge clk);
            check("cfg_axon", {31'b0, axon}, 32'd0);
        end
        if (nbits == L) begin
            config_en = 1'b0;
            bs_in     = 1'b0;
            cur_chain = bits;
        end
    endtask

    task automatic do_reset_nn();
        reset_nn = 1'b1;
        @(negedge clk);
        reset_nn = 1'b0;
        check("reset_nn_pot", {26'b0, dut.pot_q}, 32'd1);
        check("reset_nn_axon", {31'b0, axon}, 32'd0);
    endtask

    task automatic apply_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i < hi; i++) begin
            dendrite = vtab[i].dend;
            clockbus = vtab[i].cb;
            e.nm = vtab[i].nm; e.ea = vtab[i].ea; e.ep = vtab[i].ep;
            sbq.push_back(e);
            @(negedge clk);
            e = sbq.pop_front();
            check({e.nm, "_axon"}, {31'b0, axon}, {31'b0, e.ea});
            check({e.nm, "_pot"}, {26'b0, dut.pot_q}, {26'b0, e.ep});
        end
        dendrite = '0;
        clockbus = '0;
    endtask

    initial begin
        int sB, eB, sC1, eC1, sC0, eC0, sN, eN, sM, eM, sD, eD, sR25, eR25, sR, eR;
        logic [L-1:0] cfgB, pat_p, pat_q;
        cfg_fields_t  cref;

        // Stimulus table: {name, dendrite, clockbus, expected axon, expected pot}
        sB = vtab.size();
        addv("B1", 4'b0011, 8'h00, 1'b0, 6'd6);
        addv("B2", 4'b0011, 8'h00, 1'b1, 6'd0);
        addv("B3", 4'b0000, 8'h00, 1'b0, 6'd0);
        addv("B4", 4'b0100, 8'h00, 1'b0, 6'd0);
        addv("B5", 4'b1000, 8'h00, 1'b0, 6'd1);
        addv("B6", 4'b1111, 8'h00, 1'b0, 6'd6);
        addv("B7", 4'b1111, 8'h00, 1'b1, 6'd0);
        eB = vtab.size();
        sC1 = vtab.size();
        addv("C1a", 4'b1111, 8'h00, 1'b0, 6'd29);
        addv("C1b", 4'b1111, 8'h00, 1'b0, 6'd57);
        addv("C1c", 4'b0001, 8'h00, 1'b1, 6'd0);
        eC1 = vtab.size();
        sC0 = vtab.size();
        addv("T0a", 4'b1111, 8'h00, 1'b0, 6'd29);
        addv("T0b", 4'b1111, 8'h00, 1'b0, 6'd57);
        addv("T0c", 4'b1111, 8'h00, 1'b0, 6'd63);
        addv("T0d", 4'b1111, 8'h00, 1'b0, 6'd63);
        addv("T0e", 4'b0000, 8'h00, 1'b0, 6'd63);
        eC0 = vtab.size();
        sN = vtab.size();
        addv("N1", 4'b0001, 8'h00, 1'b0, 6'd5);
        eN = vtab.size();
        sM = vtab.size();
        addv("M1", 4'b1111, 8'h00, 1'b0, 6'd0);
        addv("M2", 4'b0001, 8'h00, 1'b0, 6'd0);
        eM = vtab.size();
        sD = vtab.size();
        addv("D0", 4'b0111, 8'h00, 1'b0, 6'd20);
        addv("D1", 4'b0000, 8'hFD, 1'b0, 6'd20);
        addv("D2", 4'b0000, 8'h02, 1'b0, 6'd10);
        addv("D3", 4'b0000, 8'h02, 1'b0, 6'd5);
        addv("D4", 4'b0000, 8'h02, 1'b0, 6'd2);
        addv("D5", 4'b0000, 8'h02, 1'b0, 6'd1);
        addv("D6", 4'b0000, 8'h02, 1'b0, 6'd0);
        addv("D7", 4'b0000, 8'h02, 1'b0, 6'd0);
        eD = vtab.size();
        sR25 = vtab.size();
        for (int i = 0; i < 4; i++) addv("CONT", 4'b0001, 8'h00, 1'b1, 6'd0);
        eR25 = vtab.size();
        sR = vtab.size();
        for (int i = 0; i < 8; i++) addv("REFR", 4'b0001, 8'h00, (i % 4) == 0, 6'd0);
        eR = vtab.size();

        rst_n = 1'b0; reset_nn = 1'b0; config_en = 1'b0; bs_in = 1'b0;
        clockbus = '0; dendrite = '0; cur_chain = '0;

        // Reset state
        #12;
        check("rst_axon", {31'b0, axon}, 32'd0);
        check("rst_bs_out", {31'b0, bs_out}, 32'd0);
        check("rst_pot", {26'b0, dut.pot_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic integrate and fire
        cfgB = mk(3, 2, -1, 1, 8, 0);
        shift_cfg(cfgB, L);
        do_reset_nn();
        apply_range(sB, eB);

        // Upper clamp then fire at threshold 63
        shift_cfg(mk(7, 7, 7, 7, 63, 0), L);
        do_reset_nn();
        apply_range(sC1, eC1);

        // Threshold 0 never fires but saturates
        shift_cfg(mk(7, 7, 7, 7, 0, 0), L);
        do_reset_nn();
        apply_range(sC0, eC0);

        // Build pot 5, reconfigure (pot must hold), then clamp at 0
        shift_cfg(mk(4, 4, 4, 4, 63, 0), L);
        do_reset_nn();
        apply_range(sN, eN);
        shift_cfg(mk(-8, -8, -8, -8, 63, 0), L);
        check("cfg_hold_pot", {26'b0, dut.pot_q}, 32'd5);
        apply_range(sM, eM);

        // Decay through selected clockbus line only
        shift_cfg(mk(7, 7, 5, 0, 63, 1), L);
        do_reset_nn();
        apply_range(sD, eD);

        // Continuous firing with no refractory period
        shift_cfg(mk(3, 0, 0, 0, 2, 0), L);
        do_reset_nn();
        apply_range(sR25, eR25);

`ifdef RETOSPECT_NEURON_REFRACTORY_EN
        // Refractory period 3
        cref = cfg_fields_t'(mk(3, 0, 0, 0, 2, 0));
        cref.refr = 3'd3;
        shift_cfg(cref, L);
        do_reset_nn();
        apply_range(sR, eR);
`else
        cref = cfg_fields_t'(mk(3, 0, 0, 0, 2, 0));
        shift_cfg(cref, L);
        do_reset_nn();
        apply_range(sR25, eR25);
        if (eR < sR) $display("empty refractory table");
`endif

        // Chain pass-through: second pattern pushes the first out bit-exact
        for (int i = 0; i < L; i++) begin
            pat_p[i] = 1'($urandom_range(0, 1));
            pat_q[i] = 1'($urandom_range(0, 1));
        end
        shift_cfg(pat_p, L);
        shift_cfg(pat_q, L);

        // Async reset mid-shift clears everything
        shift_cfg(cfgB, 17);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bs_out", {31'b0, bs_out}, 32'd0);
        check("midrst_axon", {31'b0, axon}, 32'd0);
        check("midrst_pot", {26'b0, dut.pot_q}, 32'd0);
        cur_chain = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        config_en = 1'b0;
        bs_in     = 1'b0;
        shift_cfg(cfgB, L);
        do_reset_nn();
        apply_range(sB, eB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
